// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: two-source packet round-robin arbiter, one-entry output reg.
// Optional macro PKT_COUNT_EN adds per-source completed-packet counters.
module stream_rr_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic              s1_last,
  input  logic [DATA_W-1:0] s2_data,
  input  logic              s2_valid,
  output logic              s2_ready,
  input  logic              s2_last,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [1:0]        grant
`ifdef PKT_COUNT_EN
  ,
  output logic [7:0]        s1_pkt_cnt,
  output logic [7:0]        s2_pkt_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT1 = 2'b01,
    GNT2 = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic                ls2_q, ls2_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic                out_free;
  logic                acc1, acc2;

  assign out_free = !m_valid_q || m_ready;
  assign s1_ready = (state_q == GNT1) && out_free;
  assign s2_ready = (state_q == GNT2) && out_free;
  assign acc1     = s1_valid && s1_ready;
  assign acc2     = s2_valid && s2_ready;

  assign grant    = state_q;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;

  // Arbitration: ties go to the source not served last; hold for the packet.
  always_comb begin
    state_d = state_q;
    ls2_d   = ls2_q;
    unique case (state_q)
      IDLE: begin
        if (s1_valid && (!s2_valid || ls2_q)) begin
          state_d = GNT1;
          ls2_d   = 1'b0;
        end else if (s2_valid) begin
          state_d = GNT2;
          ls2_d   = 1'b1;
        end
      end
      GNT1: if (acc1 && s1_last) state_d = IDLE;
      GNT2: if (acc2 && s2_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output register: load on accept, drain when the sink takes the beat.
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    if (acc1) begin
      m_data_d  = s1_data;
      m_last_d  = s1_last;
      m_valid_d = 1'b1;
    end else if (acc2) begin
      m_data_d  = s2_data;
      m_last_d  = s2_last;
      m_valid_d = 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State and output registers; reset favours source 1 on the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ls2_q     <= 1'b1;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ls2_q     <= ls2_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

`ifdef PKT_COUNT_EN
  logic [7:0] cnt1_q, cnt1_d;
  logic [7:0] cnt2_q, cnt2_d;

  assign cnt1_d     = cnt1_q + ((acc1 && s1_last) ? 8'd1 : 8'd0);
  assign cnt2_d     = cnt2_q + ((acc2 && s2_last) ? 8'd1 : 8'd0);
  assign s1_pkt_cnt = cnt1_q;
  assign s2_pkt_cnt = cnt2_q;

  // Completed-packet counters, wrapping at 8 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt1_q <= 8'd0;
      cnt2_q <= 8'd0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: scoreboard bench with a packet-level round-robin model.
// Build with PKT_COUNT_EN defined to also exercise the packet counters.
module tb_stream_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] s1_data = '0, s2_data = '0;
  logic       s1_valid = 1'b0, s2_valid = 1'b0;
  logic       s1_last = 1'b0, s2_last = 1'b0;
  logic       m_ready = 1'b0;
  logic       s1_ready, s2_ready;
  logic [7:0] m_data;
  logic       m_valid, m_last;
  logic [1:0] grant;
`ifdef PKT_COUNT_EN
  logic [7:0] c1, c2;
`endif

  stream_rr_arbiter #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .s1_data(s1_data), .s1_valid(s1_valid),
    .s1_ready(s1_ready), .s1_last(s1_last),
    .s2_data(s2_data), .s2_valid(s2_valid),
    .s2_ready(s2_ready), .s2_last(s2_last),
    .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last),
    .grant(grant)
`ifdef PKT_COUNT_EN
    , .s1_pkt_cnt(c1), .s2_pkt_cnt(c2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t q1[$], q2[$];
  beat_t st1[$], st2[$];
  beat_t expq[$];
  int checks = 0, errors = 0;
  int gap_pct = 0, rdy_pct = 100, s2_pause = 0;
  int pos1 = 0, pos2 = 0;
  int model_last = 2;
  int mc1 = 0, mc2 = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_beat(input int src, input logic [7:0] d,
                          input logic l, input bit exp);
    beat_t b;
    b.d = d;
    b.l = l;
    if (src == 1) begin
      q1.push_back(b);
      if (exp) st1.push_back(b);
    end else begin
      q2.push_back(b);
      if (exp) st2.push_back(b);
    end
  endtask

  task automatic add_pkt(input int src, input int len);
    for (int i = 0; i < len; i++)
      add_beat(src, 8'($urandom), (i == len - 1), 1'b1);
  endtask

  // Packet-order model: whole packets, ties alternate from last winner.
  task automatic run_model();
    int pick;
    beat_t b;
    while (st1.size() > 0 || st2.size() > 0) begin
      if (st1.size() > 0 && st2.size() > 0)
        pick = (model_last == 1) ? 2 : 1;
      else
        pick = (st1.size() > 0) ? 1 : 2;
      do begin
        b = (pick == 1) ? st1.pop_front() : st2.pop_front();
        expq.push_back(b);
      end while (!b.l);
      if (pick == 1) mc1 = (mc1 + 1) % 256;
      else mc2 = (mc2 + 1) % 256;
      model_last = pick;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_last = 2;
    mc1 = 0;
    mc2 = 0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((expq.size() > 0 || q1.size() > 0 || q2.size() > 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats left expected 0", expq.size());
      expq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Source and sink drivers: change inputs just after each rising edge.
  initial begin
    bit hs1, hs2;
    forever begin
      @(negedge clk);
      hs1 = s1_valid && s1_ready;
      hs2 = s2_valid && s2_ready;
      @(posedge clk);
      #1;
      if (reset) begin
        q1.delete();
        q2.delete();
        pos1 = 0;
        pos2 = 0;
        s1_valid = 1'b0;
        s2_valid = 1'b0;
        s1_last = 1'b0;
        s2_last = 1'b0;
      end else begin
        if (hs1) begin
          pos1 = q1[0].l ? 0 : pos1 + 1;
          void'(q1.pop_front());
        end
        if (hs2) begin
          pos2 = q2[0].l ? 0 : pos2 + 1;
          void'(q2.pop_front());
        end
        s1_valid = (q1.size() > 0) &&
                   (pos1 == 0 || $urandom_range(99) >= gap_pct);
        if (s2_pause > 0 && pos2 > 0 && q2.size() > 0) begin
          s2_valid = 1'b0;
          s2_pause--;
        end else begin
          s2_valid = (q2.size() > 0) &&
                     (pos2 == 0 || $urandom_range(99) >= gap_pct);
        end
        if (q1.size() > 0) begin
          s1_data = q1[0].d;
          s1_last = q1[0].l;
        end else begin
          s1_data = 8'($urandom);
          s1_last = 1'b0;
        end
        if (q2.size() > 0) begin
          s2_data = q2[0].d;
          s2_last = q2[0].l;
        end else begin
          s2_data = 8'($urandom);
          s2_last = 1'b0;
        end
      end
      m_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  // Monitor: scoreboard pops plus per-cycle handshake rules.
  initial begin
    bit p_hs = 0, p_hold = 0, p_lin = 0;
    logic [7:0] p_d = '0, h_d = '0;
    logic p_l = 0, h_l = 0;
    beat_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_hs = 0;
        p_hold = 0;
        p_lin = 0;
        continue;
      end
      chk("s1_ready_rule", s1_ready,
          (grant == 2'b01) && (!m_valid || m_ready));
      chk("s2_ready_rule", s2_ready,
          (grant == 2'b10) && (!m_valid || m_ready));
      if (grant == 2'b11) chk("grant_onehot", grant, 2'b00);
      if (p_hs) begin
        chk("latency_valid", m_valid, 1'b1);
        chk("latency_data", m_data, p_d);
        chk("latency_last", m_last, p_l);
      end
      if (p_hold) begin
        chk("hold_valid", m_valid, 1'b1);
        chk("hold_data", m_data, h_d);
        chk("hold_last", m_last, h_l);
      end
      if (p_lin) chk("idle_gap", grant, 2'b00);
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", m_data);
        end else begin
          e = expq.pop_front();
          chk("out_data", m_data, e.d);
          chk("out_last", m_last, e.l);
        end
      end
      p_hs = (s1_valid && s1_ready) || (s2_valid && s2_ready);
      p_d = (s1_valid && s1_ready) ? s1_data : s2_data;
      p_l = (s1_valid && s1_ready) ? s1_last : s2_last;
      p_lin = p_hs && p_l;
      p_hold = m_valid && !m_ready;
      h_d = m_data;
      h_l = m_last;
    end
  end

  initial begin
    #2 reset = 1'b1;
    #3;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s1_ready", s1_ready, 1'b0);
    chk("rst_s2_ready", s2_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Single source, four beats.
    add_beat(1, 8'hA1, 1'b0, 1'b1);
    add_beat(1, 8'hB2, 1'b0, 1'b1);
    add_beat(1, 8'hC3, 1'b0, 1'b1);
    add_beat(1, 8'hD4, 1'b1, 1'b1);
    run_model();
    drain(200);
    chk("idle_after_pkt", grant, 2'b00);

    // Tie out of reset: s1, s2, s1, s2.
    do_reset();
    add_pkt(1, 3);
    add_pkt(2, 3);
    add_pkt(1, 3);
    add_pkt(2, 3);
    run_model();
    drain(200);

    // Backpressure mid-packet.
    add_pkt(1, 6);
    run_model();
    repeat (3) @(negedge clk);
    rdy_pct = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_s1_ready", s1_ready, 1'b0);
      chk("bp_m_valid", m_valid, 1'b1);
    end
    rdy_pct = 100;
    drain(200);

    // s2 valid gap while s1 waits; last winner was s1.
    add_pkt(2, 8);
    add_pkt(1, 3);
    run_model();
    repeat (4) @(negedge clk);
    s2_pause = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("gap_grant", grant, 2'b10);
    end
    drain(200);

    // Randomized traffic with gaps and backpressure.
    do_reset();
    gap_pct = 30;
    rdy_pct = 70;
    for (int i = 0; i < 12; i++) begin
      add_pkt(1, $urandom_range(1, 5));
      add_pkt(2, $urandom_range(1, 5));
    end
    for (int i = 0; i < 3; i++) add_pkt(1, $urandom_range(1, 4));
    run_model();
    drain(4000);
    gap_pct = 0;

    // Reset mid-packet: in-flight beat and remainder dropped.
    rdy_pct = 0;
    add_beat(1, 8'h11, 1'b0, 1'b0);
    add_beat(1, 8'h22, 1'b0, 1'b0);
    add_beat(1, 8'h33, 1'b0, 1'b0);
    add_beat(1, 8'h44, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    chk("stall_valid", m_valid, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mrst_grant", grant, 2'b00);
    chk("mrst_m_valid", m_valid, 1'b0);
    chk("mrst_m_last", m_last, 1'b0);
    chk("mrst_m_data", m_data, 8'h00);
    chk("mrst_s1_ready", s1_ready, 1'b0);
    model_last = 2;
    mc1 = 0;
    mc2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rdy_pct = 100;
    add_pkt(2, 2);
    add_pkt(1, 2);
    run_model();
    drain(200);

`ifdef PKT_COUNT_EN
    do_reset();
    chk("cnt1_rst", c1, 8'd0);
    chk("cnt2_rst", c2, 8'd0);
    for (int i = 0; i < 257; i++) add_pkt(1, 1);
    run_model();
    drain(2000);
    chk("cnt1_wrap", c1, 8'(mc1));
    chk("cnt2_zero", c2, 8'(mc2));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
